// File: rtl/crc_pkg.sv
// Shared types and default constants for the parallel CRC engine.
package crc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } crc_state_e;

    localparam int unsigned CRC_W_DEF = 9;
    localparam logic [8:0]  POLY_DEF  = 9'h103;
    localparam int unsigned PAR_DEF   = 3;

endpackage

// File: rtl/crc_par_step.sv
// Combinational PAR-bit step of a serial CRC LFSR; the earliest bit (MSB of data) goes in first.
module crc_par_step #(
    parameter int unsigned      CRC_W = 9,
    parameter logic [CRC_W-1:0] POLY  = 9'h103,
    parameter int unsigned      PAR   = 3
) (
    input  logic [CRC_W-1:0] rem_in,
    input  logic [PAR-1:0]   data,
    output logic [CRC_W-1:0] rem_out
);

    always_comb begin
        logic [CRC_W-1:0] r;
        logic             fb;
        r  = rem_in;
        fb = 1'b0;
        for (int i = int'(PAR) - 1; i >= 0; i--) begin
            fb = data[i] ^ r[CRC_W-1];
            r  = (r << 1) ^ (fb ? POLY : '0);
        end
        rem_out = r;
    end

endmodule

// File: rtl/three_parallel_crc_engine.sv
// Streaming CRC generator/checker consuming PAR message bits per beat, one result per message.
module three_parallel_crc_engine
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W = CRC_W_DEF,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(POLY_DEF),
    parameter int unsigned      PAR   = PAR_DEF,
    parameter int unsigned      CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [PAR-1:0]   in_data,
    input  logic             chk_mode,
    output logic             crc_valid,
    input  logic             crc_ready,
    output logic [CRC_W-1:0] crc_out,
    output logic             crc_ok,
    output logic [CNT_W-1:0] beat_cnt
);

    crc_state_e       state_q, state_d;
    logic [CRC_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;

    logic             done;
    logic             accept;
    logic             take;
    logic             load;
    logic             extend;
    logic [CRC_W-1:0] step_in;
    logic [CRC_W-1:0] step_out;

    assign done     = (state_q == StDone);
    assign in_ready = !done || crc_ready;
    assign accept   = in_valid && in_ready;
    assign take     = done && crc_ready;
    assign load     = accept && in_sop;
    // Non-sop beats only count while a message is open; in IDLE or DONE they are dropped.
    assign extend   = accept && !in_sop && (state_q == StBusy);
    assign step_in  = in_sop ? '0 : rem_q;

    crc_par_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .PAR   (PAR)
    ) u_step (
        .rem_in  (step_in),
        .data    (in_data),
        .rem_out (step_out)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = in_eop ? StDone : StBusy;
                end
            end
            StBusy: begin
                if (accept && in_eop) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (load) begin
                    state_d = in_eop ? StDone : StBusy;
                end else if (take) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (load) begin
            rem_d  = step_out;
            cnt_d  = CNT_W'(1);
            mode_d = chk_mode;
        end else if (extend) begin
            rem_d = step_out;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            rem_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign crc_valid = done;
    assign crc_out   = done ? rem_q : '0;
    assign crc_ok    = done && mode_q && (rem_q == '0);
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_three_parallel_crc_engine.sv
// Directed and randomised checks of the parallel CRC engine at PAR = 3, 1 and 9.
module tb_three_parallel_crc_engine;

    logic       clk = 1'b0;
    logic       reset;

    logic       in_valid, in_ready, in_sop, in_eop, chk_mode;
    logic [2:0] in_data;
    logic       crc_valid, crc_ready, crc_ok;
    logic [8:0] crc_out;
    logic [15:0] beat_cnt;

    logic       p1_valid, p1_ready, p1_sop, p1_eop, p1_crc_valid, p1_crc_ok;
    logic [0:0] p1_data;
    logic [8:0] p1_crc;
    logic [2:0] p1_cnt;

    logic       p9_valid, p9_ready, p9_sop, p9_eop, p9_crc_valid, p9_crc_ok;
    logic [8:0] p9_data;
    logic [8:0] p9_crc;
    logic [15:0] p9_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    three_parallel_crc_engine dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_data   (in_data),
        .chk_mode  (chk_mode),
        .crc_valid (crc_valid),
        .crc_ready (crc_ready),
        .crc_out   (crc_out),
        .crc_ok    (crc_ok),
        .beat_cnt  (beat_cnt)
    );

    three_parallel_crc_engine #(.PAR(1), .CNT_W(3)) dut_p1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (p1_valid),
        .in_ready  (p1_ready),
        .in_sop    (p1_sop),
        .in_eop    (p1_eop),
        .in_data   (p1_data),
        .chk_mode  (1'b0),
        .crc_valid (p1_crc_valid),
        .crc_ready (1'b1),
        .crc_out   (p1_crc),
        .crc_ok    (p1_crc_ok),
        .beat_cnt  (p1_cnt)
    );

    three_parallel_crc_engine #(.PAR(9)) dut_p9 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (p9_valid),
        .in_ready  (p9_ready),
        .in_sop    (p9_sop),
        .in_eop    (p9_eop),
        .in_data   (p9_data),
        .chk_mode  (1'b0),
        .crc_valid (p9_crc_valid),
        .crc_ready (1'b1),
        .crc_out   (p9_crc),
        .crc_ok    (p9_crc_ok),
        .beat_cnt  (p9_cnt)
    );

    typedef struct {
        logic        chk;
        int          n;
        logic [17:0] bits;   // beats left-justified, earliest beat in [17:15]
        logic [8:0]  crc;
        logic        ok;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input logic chk, input int n, input logic [17:0] bits);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_sop   = (k == 0);
            in_eop   = (k == n - 1);
            in_data  = bits[17 - 3 * k -: 3];
            chk_mode = chk;
            tick();
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    // Bit-serial reference: remainder of M(y)*y^9 mod (y^9+y^8+y+1), bit n-1 first.
    function automatic logic [8:0] ref_crc(input logic [35:0] m, input int n);
        logic [8:0] r;
        logic       fb;
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = m[i] ^ r[8];
            r  = {r[7:0], 1'b0} ^ (fb ? 9'h103 : 9'h000);
        end
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [35:0] msg;
        logic [8:0]  exp;
        int          nb;
        int          saw_valid;

        vecs[0] = '{1'b0, 3, 18'b101011010_000000000, 9'h0B6, 1'b0, 16'd3};
        vecs[1] = '{1'b1, 6, 18'b101011010_010110110, 9'h000, 1'b1, 16'd6};
        vecs[2] = '{1'b1, 6, 18'b101011010_011110110, 9'h181, 1'b0, 16'd6};
        vecs[3] = '{1'b0, 1, 18'b101_000000000000000, 9'h00A, 1'b0, 16'd1};
        vecs[4] = '{1'b1, 1, 18'b000_000000000000000, 9'h000, 1'b1, 16'd1};
        vecs[5] = '{1'b0, 2, 18'b101011_000000000000, 9'h056, 1'b0, 16'd2};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_data   = '0;
        chk_mode  = 1'b0;
        crc_ready = 1'b1;
        p1_valid  = 1'b0;
        p1_sop    = 1'b0;
        p1_eop    = 1'b0;
        p1_data   = '0;
        p9_valid  = 1'b0;
        p9_sop    = 1'b0;
        p9_eop    = 1'b0;
        p9_data   = '0;

        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_crc_valid", crc_valid, 0);
        check("rst_crc_out", crc_out, 0);
        check("rst_crc_ok", crc_ok, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        reset = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            send_msg(vecs[v].chk, vecs[v].n, vecs[v].bits);
            check($sformatf("vec%0d_valid", v), crc_valid, 1);
            check($sformatf("vec%0d_crc", v), crc_out, vecs[v].crc);
            check($sformatf("vec%0d_ok", v), crc_ok, vecs[v].ok);
            check($sformatf("vec%0d_cnt", v), beat_cnt, vecs[v].cnt);
            tick();
            check($sformatf("vec%0d_taken", v), crc_valid, 0);
        end

        // Backpressure: result held, next sop accepted in the same cycle crc_ready returns.
        crc_ready = 1'b0;
        send_msg(1'b0, 3, vecs[0].bits);
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_data  = 3'b101;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d_valid", k), crc_valid, 1);
            check($sformatf("hold%0d_crc", k), crc_out, 9'h0B6);
            check($sformatf("hold%0d_cnt", k), beat_cnt, 3);
            check($sformatf("hold%0d_in_ready", k), in_ready, 0);
            tick();
        end
        crc_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        tick();
        check("b2b_valid_low", crc_valid, 0);
        check("b2b_cnt", beat_cnt, 1);
        in_sop  = 1'b0;
        in_data = 3'b011;
        tick();
        in_eop  = 1'b1;
        in_data = 3'b010;
        tick();
        in_valid = 1'b0;
        in_eop   = 1'b0;
        check("b2b_result_valid", crc_valid, 1);
        check("b2b_result_crc", crc_out, 9'h0B6);
        check("b2b_result_cnt", beat_cnt, 3);
        tick();

        // Abort: a fresh sop mid-message restarts from zero with no result for the old one.
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_data  = 3'b101;
        tick();
        check("abort_beat1_valid", crc_valid, 0);
        in_sop  = 1'b0;
        in_data = 3'b011;
        tick();
        check("abort_beat2_valid", crc_valid, 0);
        send_msg(1'b0, 3, vecs[0].bits);
        check("abort_result_valid", crc_valid, 1);
        check("abort_result_crc", crc_out, 9'h0B6);
        check("abort_result_cnt", beat_cnt, 3);
        tick();

        // Reset mid-message discards context.
        in_valid = 1'b1;
        in_sop   = 1'b1;
        in_data  = 3'b101;
        tick();
        in_sop  = 1'b0;
        in_data = 3'b011;
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("midrst_crc_valid", crc_valid, 0);
        check("midrst_crc_out", crc_out, 0);
        check("midrst_crc_ok", crc_ok, 0);
        check("midrst_beat_cnt", beat_cnt, 0);
        check("midrst_in_ready", in_ready, 1);
        tick();
        reset = 1'b1;
        // An eop beat without sop in IDLE must be dropped.
        in_valid = 1'b1;
        in_eop   = 1'b1;
        in_data  = 3'b010;
        saw_valid = 0;
        tick();
        in_valid = 1'b0;
        in_eop   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (crc_valid) saw_valid++;
            tick();
        end
        check("midrst_no_result", saw_valid, 0);
        check("drop_beat_cnt", beat_cnt, 0);

        // Random messages on PAR = 3, 1 and 9 in parallel against the serial reference.
        for (int t = 0; t < 10; t++) begin
            nb  = 9 * $urandom_range(1, 4);
            msg = {$urandom(), $urandom()};
            exp = ref_crc(msg, nb);
            for (int c = 0; c < nb; c++) begin
                p1_valid = 1'b1;
                p1_sop   = (c == 0);
                p1_eop   = (c == nb - 1);
                p1_data  = msg[nb - 1 - c];
                if (c < nb / 3) begin
                    in_valid = 1'b1;
                    in_sop   = (c == 0);
                    in_eop   = (c == nb / 3 - 1);
                    in_data  = msg[nb - 1 - 3 * c -: 3];
                    chk_mode = 1'b0;
                end else begin
                    in_valid = 1'b0;
                end
                if (c < nb / 9) begin
                    p9_valid = 1'b1;
                    p9_sop   = (c == 0);
                    p9_eop   = (c == nb / 9 - 1);
                    p9_data  = msg[nb - 1 - 9 * c -: 9];
                end else begin
                    p9_valid = 1'b0;
                end
                tick();
                if (c == nb / 3 - 1) begin
                    check($sformatf("sweep%0d_p3_valid", t), crc_valid, 1);
                    check($sformatf("sweep%0d_p3_crc", t), crc_out, exp);
                    check($sformatf("sweep%0d_p3_ok", t), crc_ok, 0);
                end
                if (c == nb / 9 - 1) begin
                    check($sformatf("sweep%0d_p9_valid", t), p9_crc_valid, 1);
                    check($sformatf("sweep%0d_p9_crc", t), p9_crc, exp);
                end
                if (c == nb - 1) begin
                    check($sformatf("sweep%0d_p1_valid", t), p1_crc_valid, 1);
                    check($sformatf("sweep%0d_p1_crc", t), p1_crc, exp);
                end
            end
            p1_valid = 1'b0;
            p9_valid = 1'b0;
            in_valid = 1'b0;
            tick();
        end

        // 3-bit counter on the PAR=1 instance saturates at 7 over a 10-beat message.
        msg = 36'h0000002D5;
        exp = ref_crc(msg, 10);
        for (int c = 0; c < 10; c++) begin
            p1_valid = 1'b1;
            p1_sop   = (c == 0);
            p1_eop   = (c == 9);
            p1_data  = msg[9 - c];
            tick();
        end
        p1_valid = 1'b0;
        check("sat_p1_valid", p1_crc_valid, 1);
        check("sat_p1_cnt", p1_cnt, 7);
        check("sat_p1_crc", p1_crc, exp);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/three_parallel_crc_engine.md
THREE_PARALLEL_CRC_ENGINE -- requirements
Module: three_parallel_crc_engine

Interface
REQ-001 Parameter CRC_W, default 9: generator degree and remainder width.
REQ-002 Parameter POLY, default 9'h103: generator coefficients y^(CRC_W-1)..y^0, with the y^CRC_W term implicit; the default is 1+y+y^8+y^9.
REQ-003 Parameter PAR, default 3: message bits consumed per accepted beat, range 1..CRC_W.
REQ-004 Parameter CNT_W, default 16: width of the beat counter.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  beat offered.
REQ-008 in_ready  out  1  beat can be accepted.
REQ-009 in_sop  in  1  first beat of a message.
REQ-010 in_eop  in  1  last beat of a message; may coincide with in_sop.
REQ-011 in_data  in  PAR  message bits; bit PAR-1 is the earliest bit.
REQ-012 chk_mode  in  1  sampled on the sop beat; 0 = generate, 1 = check.
REQ-013 crc_valid  out  1  result available.
REQ-014 crc_ready  in  1  result consumed.
REQ-015 crc_out  out  CRC_W  remainder of M(y)*y^CRC_W mod G(y), MSB = y^(CRC_W-1).
REQ-016 crc_ok  out  1  in check mode, high when crc_out==0; forced 0 in generate mode.
REQ-017 beat_cnt  out  CNT_W  beats accepted in the current or last message, saturating at all-ones.

Function
REQ-018 A beat is accepted in a cycle when in_valid and in_ready are both 1; a result is taken in a cycle when crc_valid and crc_ready are both 1.
REQ-019 FSM states: IDLE, BUSY, DONE.
- IDLE to BUSY: sop beat accepted without eop.
- IDLE or BUSY to DONE: sop+eop beat accepted, or eop beat accepted in BUSY.
- DONE to IDLE: result taken with no beat accepted in the same cycle.
REQ-020 The remainder register updates each accepted beat by the PAR-step unrolled serial-LFSR recurrence, equal to PAR serial shifts, earliest bit first.
REQ-021 A sop beat loads the register from zero before applying its bits.
REQ-022 An eop beat is accepted at cycle T; crc_valid rises at T+1 with crc_out, crc_ok and beat_cnt final.
REQ-023 crc_out, crc_ok and beat_cnt are held stable while crc_valid=1 and crc_ready=0.
REQ-024 in_ready = (state != DONE) | crc_ready; this allows back-to-back messages with zero bubble.
REQ-025 In DONE, if a result is taken and a sop beat is accepted in the same cycle, the next state is BUSY, or DONE when that beat also has eop.
REQ-026 A sop beat accepted in BUSY aborts the current message and restarts from zero; no result is produced for the aborted message.
REQ-027 A beat without sop accepted in IDLE is dropped; state and register are unchanged.
REQ-028 beat_cnt is set to 1 on a sop beat and increments on each further accepted beat; it saturates at all-ones and does not wrap.
REQ-029 Message length is always a multiple of PAR; there is no partial-beat support.

Reset
REQ-030 While reset=0:
- state is IDLE;
- remainder and beat_cnt are 0;
- crc_valid, crc_ok and crc_out are 0;
- in_ready is 1.
REQ-031 Reset asserted mid-message or in DONE discards all context with no result; the first cycle after release behaves as IDLE.

Structure
REQ-032 Package crc_pkg holds:
- the FSM state enum;
- default constants CRC_W_DEF=9, POLY_DEF=9'h103 and PAR_DEF=3.
REQ-033 Sub-module crc_par_step (purely combinational; parameters CRC_W, POLY, PAR; inputs remainder and data; output next remainder) implements REQ-020. It is the only arithmetic in the design.

Verification
REQ-034 Generate mode, defaults, beats 101, 011, 010 (sop on the first, eop on the last), crc_ready=1 -> crc_valid one cycle after the eop beat; crc_out=9'h0B6, beat_cnt=3, crc_ok=0.
REQ-035 Check mode, beats 101, 011, 010, 010, 110, 110 -> crc_out=0, crc_ok=1, beat_cnt=6.
REQ-036 As REQ-035 with the fourth beat changed to 011 -> crc_ok=0 and crc_out nonzero.
REQ-037 REQ-034 run with crc_ready=0 for 5 cycles -> outputs held and in_ready=0; then crc_ready=1 with a sop beat of the next message in the same cycle -> that beat is accepted with no bubble.
REQ-038 Abort and reset:
- sop, two beats, then a new sop message identical to REQ-034 -> a single result of 9'h0B6;
- reset=0 asserted mid-message -> all outputs are 0 and no crc_valid follows.
REQ-039 Parameter sweep PAR in {1, 3, 9} on random messages -> results match a serial bit-wise reference model.
